// File: rtl/multicycle_ctrl_pkg.sv
// Shared RV32I encodings plus the multi-cycle controller state and writeback enums.
// Used by mc_decoder and multicycle_ctrl (optional MC_PERF_COUNTERS_EN lives in the top).
package multicycle_ctrl_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_I_TYPE = 7'b0010011,
        OP_R_TYPE = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0100,
        ALU_SLTU = 4'b0110,
        ALU_XOR  = 4'b1000,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011,
        ALU_OR   = 4'b1100,
        ALU_AND  = 4'b1110,
        ALU_PASS = 4'b1111
    } alu_op_t;

    // Branch codes match funct3; the two holes carry the unconditional cases.
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_PC  = 3'b010,
        BR_ALU = 3'b011,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_type_t;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } load_store_t;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } mc_state_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       a_sel;
        logic       b_sel;
        br_type_t   br_type;
        wb_sel_t    wb_sel;
        logic       legal;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
    } dec_t;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == LS_B) || (f3 == LS_H) || (f3 == LS_W) ||
               (f3 == LS_BU) || (f3 == LS_HU);
    endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decoder: datapath selects, ALU/branch codes
// and the legality flag consumed by the controller FSM.
module mc_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b;
    logic       unused_bits;

    assign op  = instr[6:0];
    assign f3  = instr[14:12];
    assign f7b = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        dec         = '0;
        dec.alu_op  = ALU_ADD;
        dec.b_sel   = 1'b1;
        dec.br_type = BR_PC;
        dec.wb_sel  = WB_ALU;
        dec.legal   = 1'b1;
        unique case (1'b1)
            op == OP_R_TYPE: begin
                dec.alu_op = {f3, f7b};
                dec.b_sel  = 1'b0;
            end
            op == OP_I_TYPE: begin
                // bit 30 is immediate data except for SRAI
                dec.alu_op = {f3, f7b & (f3 == 3'b101)};
            end
            op == OP_LUI: begin
                dec.alu_op = ALU_PASS;
            end
            op == OP_AUIPC: begin
                dec.a_sel = 1'b1;
            end
            op == OP_LOAD: begin
                dec.is_load = 1'b1;
                dec.wb_sel  = WB_MEM;
                dec.legal   = load_f3_ok(f3);
            end
            op == OP_STORE: begin
                dec.is_store = 1'b1;
                dec.legal    = (f3 <= 3'b010);
            end
            op == OP_BRANCH: begin
                dec.is_branch = 1'b1;
                dec.a_sel     = 1'b1;
                dec.br_type   = br_type_t'(f3);
                dec.legal     = (f3[2:1] != 2'b01);
            end
            op == OP_JAL: begin
                dec.a_sel   = 1'b1;
                dec.br_type = BR_ALU;
                dec.wb_sel  = WB_PC4;
            end
            op == OP_JALR: begin
                dec.br_type = BR_ALU;
                dec.wb_sel  = WB_PC4;
            end
            default: begin
                dec.legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I controller: FETCH/DECODE/EXECUTE/MEM/WB FSM with a sticky TRAP.
// Define MC_PERF_COUNTERS_EN to build the cycle and retired-instruction counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ifetch,
    output logic [2:0]  ls_type,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        a_sel,
    output logic        b_sel,
    output logic [3:0]  alu_op,
    output logic [2:0]  br_type,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    mc_state_t st;
    dec_t      dec;

    mc_decoder u_dec (
        .instr (instr),
        .dec   (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= FETCH;
            illegal <= 1'b0;
        end else begin
            unique case (st)
                FETCH:   if (mem_ready) st <= DECODE;
                DECODE: begin
                    st      <= dec.legal ? EXECUTE : TRAP;
                    illegal <= ~dec.legal;
                end
                EXECUTE: begin
                    if (dec.is_branch)
                        st <= FETCH;
                    else if (dec.is_load || dec.is_store)
                        st <= MEM;
                    else
                        st <= WB;
                end
                MEM: if (mem_ready) st <= dec.is_store ? FETCH : WB;
                WB:      st <= FETCH;
                TRAP:    st <= TRAP;
                default: st <= FETCH;
            endcase
        end
    end

    // Strobes are gated by rst_n so they drop the moment reset asserts.
    assign mem_ifetch = (st == FETCH);
    assign mem_req    = rst_n & ((st == FETCH) | (st == MEM));
    assign mem_we     = rst_n & (st == MEM) & dec.is_store;
    assign ir_we      = rst_n & (st == FETCH) & mem_ready;
    assign reg_we     = rst_n & (st == WB);
    assign pc_we      = rst_n & (((st == EXECUTE) & dec.is_branch) |
                                 ((st == MEM) & dec.is_store & mem_ready) |
                                 (st == WB));
    assign pc_sel     = pc_we & br_taken;

    assign ls_type = instr[14:12];
    assign alu_op  = dec.alu_op;
    assign a_sel   = dec.a_sel;
    assign b_sel   = dec.b_sel;
    assign br_type = dec.br_type;
    assign wb_sel  = dec.wb_sel;
    assign state   = st;

`ifdef MC_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_we) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: decode table plus per-cycle
// strobe sequences for fetch/memory waits, commits, trap and reset.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0000_0013;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_req, mem_we, mem_ifetch, ir_we, pc_we, pc_sel, reg_we;
    logic        a_sel, b_sel, illegal;
    logic [2:0]  ls_type, br_type, state;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic [31:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .br_taken    (br_taken),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ifetch  (mem_ifetch),
        .ls_type     (ls_type),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .alu_op      (alu_op),
        .br_type     (br_type),
        .state       (state),
        .illegal     (illegal),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

`ifdef MC_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;
    localparam logic [31:0] I_ADD = 32'h0020_81B3;
    localparam logic [31:0] I_LW  = 32'h0000_A283;
    localparam logic [31:0] I_SW  = 32'h0020_A223;
    localparam logic [31:0] I_BEQ = 32'h0000_0063;

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // {alu_op, a_sel, b_sel, br_type, wb_sel}
    typedef struct {
        logic [31:0] ins;
        logic [3:0]  alu;
        logic        a;
        logic        b;
        logic [2:0]  br;
        logic [1:0]  wb;
    } dvec_t;

    dvec_t dv[12];

    // {state, mem_req, mem_ifetch, mem_we, ir_we, pc_we, pc_sel, reg_we}
    logic [9:0] act;
    assign act = {state, mem_req, mem_ifetch, mem_we, ir_we,
                  pc_we, pc_sel, reg_we};

    logic [9:0] exp_s[16];
    logic       rdy_s[16];

    task automatic setc(input int i, input logic r, input logic [2:0] s,
                        input logic [6:0] x);
        rdy_s[i] = r;
        exp_s[i] = {s, x};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        br_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run(input string nm, input logic [31:0] ins,
                       input logic bt, input int n);
        do_reset();
        instr = ins;
        br_taken = bt;
        rst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ready = rdy_s[i];
            @(negedge clk);
            chk($sformatf("%s c%0d", nm, i + 1), {22'd0, act},
                {22'd0, exp_s[i]});
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] bad[4];

    initial begin
        dv[0]  = '{32'h0020_81B3, 4'b0000, 1'b0, 1'b0, 3'b010, 2'd0};
        dv[1]  = '{32'h4020_81B3, 4'b0001, 1'b0, 1'b0, 3'b010, 2'd0};
        dv[2]  = '{32'h4030_D093, 4'b1011, 1'b0, 1'b1, 3'b010, 2'd0};
        dv[3]  = '{32'hC000_8093, 4'b0000, 1'b0, 1'b1, 3'b010, 2'd0};
        dv[4]  = '{32'h1234_50B7, 4'b1111, 1'b0, 1'b1, 3'b010, 2'd0};
        dv[5]  = '{32'h0000_0097, 4'b0000, 1'b1, 1'b1, 3'b010, 2'd0};
        dv[6]  = '{32'h0000_A283, 4'b0000, 1'b0, 1'b1, 3'b010, 2'd1};
        dv[7]  = '{32'h0020_A223, 4'b0000, 1'b0, 1'b1, 3'b010, 2'd0};
        dv[8]  = '{32'h0000_0063, 4'b0000, 1'b1, 1'b1, 3'b000, 2'd0};
        dv[9]  = '{32'h0020_E463, 4'b0000, 1'b1, 1'b1, 3'b110, 2'd0};
        dv[10] = '{32'h0000_00EF, 4'b0000, 1'b1, 1'b1, 3'b011, 2'd2};
        dv[11] = '{32'h0000_8067, 4'b0000, 1'b0, 1'b1, 3'b011, 2'd2};
        bad[0] = 32'h0000_B283;
        bad[1] = 32'h0000_B023;
        bad[2] = 32'h0000_2063;
        bad[3] = 32'h0000_000F;

        // reset state
        mem_ready = 1'b1;
        #12;
        chk("reset strobes",
            {25'd0, state, mem_req, mem_we, ir_we, pc_we, reg_we, illegal},
            32'd0);
        chk("reset cycle_cnt", cycle_cnt, 32'd0);
        chk("reset instret_cnt", instret_cnt, 32'd0);

        for (int i = 0; i < 12; i++) begin
            instr = dv[i].ins;
            #1;
            chk($sformatf("decode %0d (%h)", i, dv[i].ins),
                {20'd0, alu_op, a_sel, b_sel, br_type, wb_sel},
                {20'd0, dv[i].alu, dv[i].a, dv[i].b, dv[i].br, dv[i].wb});
        end

        // ADD, no waits
        setc(0, 1'b1, S_F, 7'b1101000);
        setc(1, 1'b1, S_D, 7'b0000000);
        setc(2, 1'b1, S_E, 7'b0000000);
        setc(3, 1'b1, S_W, 7'b0000101);
        run("add", I_ADD, 1'b0, 4);
        chk("add back to fetch", {29'd0, state}, {29'd0, S_F});
        chk("add instret", instret_cnt, PERF ? 32'd1 : 32'd0);
        chk("add cycles", cycle_cnt, PERF ? 32'd4 : 32'd0);

        // LW, 2 wait cycles; ready in DECODE/EXECUTE/WB must be ignored
        setc(0, 1'b1, S_F, 7'b1101000);
        setc(1, 1'b1, S_D, 7'b0000000);
        setc(2, 1'b1, S_E, 7'b0000000);
        setc(3, 1'b0, S_M, 7'b1000000);
        setc(4, 1'b0, S_M, 7'b1000000);
        setc(5, 1'b1, S_M, 7'b1000000);
        setc(6, 1'b1, S_W, 7'b0000101);
        run("lw", I_LW, 1'b0, 7);
        chk("lw wb_sel", {30'd0, wb_sel}, 32'd1);
        chk("lw ls_type", {29'd0, ls_type}, 32'd2);

        // SW, 1 wait cycle; commit lands with mem_ready
        setc(0, 1'b1, S_F, 7'b1101000);
        setc(1, 1'b1, S_D, 7'b0000000);
        setc(2, 1'b1, S_E, 7'b0000000);
        setc(3, 1'b0, S_M, 7'b1010000);
        setc(4, 1'b1, S_M, 7'b1010100);
        setc(5, 1'b1, S_F, 7'b1101000);
        run("sw", I_SW, 1'b0, 6);
        chk("sw ls_type", {29'd0, ls_type}, 32'd2);

        // BEQ taken, 1 fetch wait; commit in EXECUTE
        setc(0, 1'b0, S_F, 7'b1100000);
        setc(1, 1'b1, S_F, 7'b1101000);
        setc(2, 1'b1, S_D, 7'b0000000);
        setc(3, 1'b1, S_E, 7'b0000110);
        setc(4, 1'b1, S_F, 7'b1101000);
        run("beq", I_BEQ, 1'b1, 5);
        chk("beq br_type", {29'd0, br_type}, 32'd0);

        // all-zero instruction traps and stays quiet for 10 cycles
        setc(0, 1'b1, S_F, 7'b1101000);
        setc(1, 1'b1, S_D, 7'b0000000);
        for (int i = 2; i < 12; i++) setc(i, 1'b1, S_T, 7'b0000000);
        run("trap", 32'h0000_0000, 1'b1, 12);
        chk("trap illegal", {31'd0, illegal}, 32'd1);
        chk("trap cycles", cycle_cnt, PERF ? 32'd12 : 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("trap async reset",
            {28'd0, state, illegal}, 32'd0);

        // funct3/opcode illegal boundaries
        setc(0, 1'b1, S_F, 7'b1101000);
        setc(1, 1'b1, S_D, 7'b0000000);
        setc(2, 1'b1, S_T, 7'b0000000);
        for (int i = 0; i < 4; i++) begin
            run($sformatf("bad%0d", i), bad[i], 1'b0, 3);
            chk($sformatf("bad%0d illegal", i), {31'd0, illegal}, 32'd1);
        end

        // reset asserted mid-MEM
        setc(0, 1'b1, S_F, 7'b1101000);
        setc(1, 1'b1, S_D, 7'b0000000);
        setc(2, 1'b1, S_E, 7'b0000000);
        setc(3, 1'b0, S_M, 7'b1000000);
        run("midmem", I_LW, 1'b0, 4);
        mem_ready = 1'b0;
        #2;
        chk("midmem before", {30'd0, state == S_M, mem_req}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midmem reset",
            {27'd0, state, mem_req, illegal}, 32'd0);
        #10;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
